des3_iter_core: RTL and testbench

- Parametrised iterative DES / Triple-DES (EDE) engine; successor to the current fixed single-DES top.
- Executes RPC Feistel rounds per clock with an on-the-fly C/D key schedule. Subkeys are not precomputed and there is no 16-way key mux.
- Uses a valid/ready handshake on both input and output, with output backpressure.
- Sits between the host data interface and the output buffer. Reuses the existing ip, ip_inverse, exp_permutation and fixedp_func permutation blocks and the standard DES S-box tables.

---
 rtl/des3_iter_core.sv | 262 ++++++++++++++++++++++++++
 tb/tb_des3_iter_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des3_iter_core.sv
// des3_iter_core: iterative DES / EDE triple-DES engine running RPC Feistel
// rounds per clock with an on-the-fly C/D key schedule and valid/ready on both sides.
module des3_iter_core #(
  parameter int RPC     = 1,
  parameter int TDES_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [63:0] i_data,
  input  logic [63:0] i_key1,
  input  logic [63:0] i_key2,
  input  logic [63:0] i_key3,
  input  logic        i_mode,
  input  logic        i_tdes,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [63:0] o_data,
  output logic        o_busy,
  output logic [1:0]  o_pass
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $error("des3_iter_core: RPC must be 1, 2, 4, 8 or 16");
  end

  // Permutation tables, DES 1-based bit numbering (DES bit n is vector bit 64-n).
  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int IPI_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                               8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                              16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                              24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27,  3,  9, 19, 13, 30, 6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // S-boxes, each 64 entries in row-major order (row = b1b6, column = b2..b5).
  localparam logic [0:7][0:63][3:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] ip_inverse(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IPI_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] exp_permutation(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] fixedp_func(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    x = exp_permutation(r) ^ k;
    for (int j = 0; j < 8; j++) begin
      b = x[47-6*j -: 6];
      s[31-4*j -: 4] = SBOX[j][{b[5], b[0], b[4:1]}];
    end
    return fixedp_func(s);
  endfunction

  // Rotation applied to C/D before round rnd; decrypt walks the schedule backwards.
  function automatic logic [1:0] shift_amt(input logic enc, input logic [4:0] rnd);
    logic [4:0] k;
    if (!enc && rnd == 5'd1) return 2'd0;
    k = enc ? rnd : 5'd18 - rnd;
    return (k == 5'd1 || k == 5'd2 || k == 5'd9 || k == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] x, input logic left, input logic [1:0] n);
    case ({left, n})
      3'b101:  return {x[26:0], x[27]};
      3'b110:  return {x[25:0], x[27:26]};
      3'b001:  return {x[0], x[27:1]};
      3'b010:  return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Key of pass p: encrypt runs K1,K2,K3; decrypt runs K3,K2,K1; single DES uses K1.
  function automatic logic [55:0] key_for(input logic [1:0] p, input logic mode, input logic tdes,
                                          input logic [55:0] a, input logic [55:0] b,
                                          input logic [55:0] c);
    if (!tdes) return a;
    case (p)
      2'd0:    return mode ? a : c;
      2'd1:    return b;
      default: return mode ? c : a;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_n;
  logic [31:0] l_q, r_q, l_n, r_n, tmp;
  logic [27:0] c_q, d_q, c_n, d_n;
  logic [55:0] k1_q, k2_q, k3_q;
  logic [4:0]  round_q, rnd;
  logic [1:0]  pass_q, pass_last, amt;
  logic        mode_q, tdes_q, tdes_in, enc_pass, end_pass, accept;

  assign tdes_in   = i_tdes && (TDES_EN != 0);
  assign enc_pass  = mode_q ^ (pass_q == 2'd1);
  assign pass_last = tdes_q ? 2'd2 : 2'd0;
  assign end_pass  = (round_q + 5'(RPC)) == 5'd16;
  assign o_pass    = pass_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_n = state_q;
    i_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b1;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        i_ready = 1'b1;
        o_busy  = 1'b0;
        if (i_valid) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN:  if (end_pass && pass_q == pass_last) state_n = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (o_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: blocking assignments here chain RPC rounds combinationally within one cycle.
  always_comb begin
    l_n = l_q;
    r_n = r_q;
    c_n = c_q;
    d_n = d_q;
    tmp = '0;
    rnd = '0;
    amt = '0;
    for (int j = 0; j < RPC; j++) begin
      rnd = round_q + 5'(j + 1);
      amt = shift_amt(enc_pass, rnd);
      c_n = rot(c_n, enc_pass, amt);
      d_n = rot(d_n, enc_pass, amt);
      tmp = r_n;
      r_n = l_n ^ feistel(r_n, pc2({c_n, d_n}));
      l_n = tmp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      k1_q    <= '0;
      mode_q  <= 1'b0;
      tdes_q  <= 1'b0;
      round_q <= '0;
      pass_q  <= '0;
      o_data  <= '0;
    end else if (accept) begin
      {l_q, r_q} <= ip(i_data);
      {c_q, d_q} <= key_for(2'd0, i_mode, tdes_in, pc1(i_key1), pc1(i_key2), pc1(i_key3));
      k1_q       <= pc1(i_key1);
      mode_q     <= i_mode;
      tdes_q     <= tdes_in;
      round_q    <= '0;
      pass_q     <= '0;
    end else if (state_q == RUN) begin
      if (end_pass) begin
        round_q <= '0;
        if (pass_q == pass_last) begin
          o_data <= ip_inverse({r_n, l_n});
        end else begin
          // IP^-1 followed by IP cancels, so the next pass starts from the swapped halves.
          {l_q, r_q} <= {r_n, l_n};
          {c_q, d_q} <= key_for(pass_q + 2'd1, mode_q, tdes_q, k1_q, k2_q, k3_q);
          pass_q     <= pass_q + 2'd1;
        end
      end else begin
        l_q     <= l_n;
        r_q     <= r_n;
        c_q     <= c_n;
        d_q     <= d_n;
        round_q <= round_q + 5'(RPC);
      end
    end
  end

  if (TDES_EN != 0) begin : g_tdes_keys
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        k2_q <= '0;
        k3_q <= '0;
      end else if (accept) begin
        k2_q <= pc1(i_key2);
        k3_q <= pc1(i_key3);
      end
    end
  end else begin : g_no_tdes_keys
    assign k2_q = '0;
    assign k3_q = '0;
  end

endmodule

// File: tb/tb_des3_iter_core.sv
// Self-checking bench for des3_iter_core: directed vectors plus random blocks
// checked against a precomputed-subkey DES / EDE reference model.
module tb_des3_iter_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_valid4, o_ready, o_ready4;
  logic [63:0] i_data, i_key1, i_key2, i_key3;
  logic        i_mode, i_tdes;
  logic        i_ready, o_valid, o_busy;
  logic [63:0] o_data;
  logic [1:0]  o_pass;
  logic        i_ready4, o_valid4, o_busy4;
  logic [63:0] o_data4;
  logic [1:0]  o_pass4;

  int n_pass  = 0;
  int n_total = 0;
  bit ready_tied = 1'b0;

  always #5 clk = ~clk;

  des3_iter_core #(.RPC(1), .TDES_EN(1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_key1(i_key1), .i_key2(i_key2), .i_key3(i_key3), .i_mode(i_mode), .i_tdes(i_tdes),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_busy(o_busy), .o_pass(o_pass));

  des3_iter_core #(.RPC(4), .TDES_EN(1)) dut4 (
    .clk(clk), .rst(rst), .i_valid(i_valid4), .i_ready(i_ready4), .i_data(i_data),
    .i_key1(i_key1), .i_key2(i_key2), .i_key3(i_key3), .i_mode(i_mode), .i_tdes(i_tdes),
    .o_valid(o_valid4), .o_ready(o_ready4), .o_data(o_data4), .o_busy(o_busy4),
    .o_pass(o_pass4));

  // Reference model tables (IP^-1 is derived from IP rather than tabulated).
  int IP_Q[$]  = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                   62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                   57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                   61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  int E_Q[$]   = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15,
                   16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27,
                   28, 29, 28, 29, 30, 31, 32, 1};
  int P_Q[$]   = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                   2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  int PC1_Q[$] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43,
                   35, 27, 19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54,
                   46, 38, 30, 22, 14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int PC2_Q[$] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7,
                   27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49,
                   39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int SHIFTS[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Result is right-aligned: output position k (1-based) lands at bit size-k.
  function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int t[$]);
    logic [63:0] y = '0;
    foreach (t[k]) y[t.size()-1-k] = x[in_w - t[k]];
    return y;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] y);
    logic [63:0] x = '0;
    foreach (IP_Q[k]) x[64 - IP_Q[k]] = y[63-k];
    return x;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    int b, row, col;
    x = 48'(perm({32'h0, r}, 32, E_Q)) ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = int'(x[47-6*j -: 6]);
      row = (b / 32) * 2 + (b % 2);
      col = (b / 2) % 16;
      s[31-4*j -: 4] = SB[j][255 - 4*(row*16 + col) -: 4];
    end
    return 32'(perm({32'h0, s}, 32, P_Q));
  endfunction

  // Classic DES: all 16 subkeys first, decryption just uses them in reverse order.
  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] key,
                                          input bit enc);
    logic [47:0] ks [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [63:0] x;
    logic [31:0] l, r, t;
    cd = 56'(perm(key, 64, PC1_Q));
    c  = cd[55:28];
    d  = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SHIFTS[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = 48'(perm({8'h0, c, d}, 56, PC2_Q));
    end
    x = perm(blk, 64, IP_Q);
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_ref(r, ks[enc ? i : 15 - i]);
      l = t;
    end
    return ip_inv({r, l});
  endfunction

  function automatic logic [63:0] model(input logic [63:0] d, input logic [63:0] k1,
                                        input logic [63:0] k2, input logic [63:0] k3,
                                        input bit mode, input bit tdes);
    if (!tdes) return des_ref(d, k1, mode);
    if (mode)  return des_ref(des_ref(des_ref(d, k1, 1), k2, 0), k3, 1);
    return des_ref(des_ref(des_ref(d, k3, 0), k2, 1), k1, 0);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One block through dut (sel=0, RPC=1) or dut4 (sel=1, RPC=4). Inputs are scrambled
  // right after accept; hold>0 keeps o_ready low that many cycles with an i_valid poke.
  task automatic run_block(input bit sel, input logic [63:0] d, input logic [63:0] k1,
                           input logic [63:0] k2, input logic [63:0] k3, input bit m,
                           input bit t, input int hold, input string tag,
                           output logic [63:0] res);
    logic [63:0] exp_data;
    int lat, cyc;
    exp_data = model(d, k1, k2, k3, m, t);
    lat = (sel ? 4 : 16) * (t ? 3 : 1);
    @(negedge clk);
    check({tag, " i_ready before accept"}, sel ? i_ready4 : i_ready, 1'b1);
    i_data = d; i_key1 = k1; i_key2 = k2; i_key3 = k3; i_mode = m; i_tdes = t;
    if (sel) i_valid4 = 1'b1;
    else     i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_valid4 = 1'b0;
    i_data = rand64(); i_key1 = rand64(); i_key2 = rand64(); i_key3 = rand64();
    i_mode = 1'($urandom); i_tdes = 1'($urandom);
    cyc = 0;
    while (!(sel ? o_valid4 : o_valid) && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = sel ? o_data4 : o_data;
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " o_data"}, res, exp_data);
    check({tag, " o_pass"}, sel ? o_pass4 : o_pass, t ? 2'd2 : 2'd0);
    if (sel || ready_tied) begin
      @(posedge clk); #1;
    end else begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        i_valid = (h == 2);
        @(posedge clk); #1;
        check({tag, " held o_data"}, o_data, exp_data);
        check({tag, " held o_valid"}, o_valid, 1'b1);
        check({tag, " held i_ready"}, i_ready, 1'b0);
      end
      @(negedge clk);
      i_valid = 1'b0;
      o_ready = 1'b1;
      @(posedge clk); #1;
      o_ready = 1'b0;
    end
    check({tag, " o_valid after take"}, sel ? o_valid4 : o_valid, 1'b0);
    check({tag, " i_ready after take"}, sel ? i_ready4 : i_ready, 1'b1);
    check({tag, " o_busy after take"}, sel ? o_busy4 : o_busy, 1'b0);
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] ka, kb, kc;
    rst = 1'b1;
    i_valid = 1'b0; i_valid4 = 1'b0; o_ready = 1'b0; o_ready4 = 1'b1;
    i_data = '0; i_key1 = '0; i_key2 = '0; i_key3 = '0; i_mode = 1'b0; i_tdes = 1'b0;
    #12;
    check("reset i_ready", i_ready, 1'b1);
    check("reset o_valid", o_valid, 1'b0);
    check("reset o_busy", o_busy, 1'b0);
    check("reset o_pass", o_pass, 2'd0);
    check("reset o_data", o_data, 64'h0);
    check("reset dut4 o_data", o_data4, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    ka = 64'h133457799BBCDFF1;
    run_block(0, 64'h0123456789ABCDEF, ka, rand64(), rand64(), 1, 0, 0, "single enc", res);
    check("single enc vector", res, 64'h85E813540F0AB405);
    run_block(0, 64'h85E813540F0AB405, ka, rand64(), rand64(), 0, 0, 0, "single dec", res);
    check("single dec vector", res, 64'h0123456789ABCDEF);
    run_block(0, 64'h8787878787878787, 64'h0E329232EA6D0D73, '0, '0, 1, 0, 0, "enc zero", res);
    check("enc zero vector", res, 64'h0000000000000000);
    run_block(0, 64'h0123456789ABCDEF, ka, ka, ka, 1, 1, 0, "tdes enc", res);
    check("tdes enc vector", res, 64'h85E813540F0AB405);
    run_block(1, 64'h0123456789ABCDEF, ka, ka, ka, 1, 1, 0, "rpc4 tdes enc", res);
    check("rpc4 tdes enc vector", res, 64'h85E813540F0AB405);

    run_block(0, rand64(), rand64(), rand64(), rand64(), 1, 1, 5, "backpressure", res);

    // Abort in the middle of the second pass (pass index 1, round 7).
    @(negedge clk);
    i_data = 64'h0123456789ABCDEF; i_key1 = ka; i_key2 = rand64(); i_key3 = rand64();
    i_mode = 1'b1; i_tdes = 1'b1; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    check("mid-op o_pass", o_pass, 2'd1);
    check("mid-op o_busy", o_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort o_valid", o_valid, 1'b0);
    check("abort o_data", o_data, 64'h0);
    check("abort o_pass", o_pass, 2'd0);
    check("abort i_ready", i_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    run_block(0, 64'h0123456789ABCDEF, ka, rand64(), rand64(), 1, 0, 0, "after abort", res);
    check("after abort vector", res, 64'h85E813540F0AB405);

    // Back-to-back random blocks, o_ready tied high, keys/mode changing during RUN.
    ready_tied = 1'b1;
    o_ready    = 1'b1;
    for (int n = 0; n < 6; n++) begin
      ka = rand64(); kb = rand64(); kc = rand64();
      run_block(0, rand64(), ka, kb, kc, 1'($urandom), 1'(n % 3 != 0), 0, "random b2b", res);
    end
    ready_tied = 1'b0;
    o_ready    = 1'b0;
    for (int n = 0; n < 3; n++) begin
      ka = rand64(); kb = rand64(); kc = rand64();
      run_block(1, rand64(), ka, kb, kc, 1'($urandom), 1'($urandom), 0, "random rpc4", res);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
